// File: rtl/rv32i_pkg.sv
// Shared encodings, the decoded-bundle layout and immediate extraction for the
// RV32I decode stage.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

    localparam int FOP_OPC_LSB = 0;
    localparam int FOP_F3_LSB  = 7;
    localparam int FOP_F7_LSB  = 10;
    localparam int FOP_W       = 17;

    typedef struct packed {
        logic [FOP_W-1:0] full_op;
        logic [31:0]      v1;
        logic [31:0]      v2;
        logic [31:0]      cmp_a;
        logic [31:0]      cmp_b;
        logic [31:0]      link;
        logic [31:0]      pc;
        logic [4:0]       rd;
        logic             rd_we;
        logic             illegal;
    } bundle_t;

    function automatic logic [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] i);
        return {i[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/rv32i_decode_stage_if.sv
// Fetch-side, register-file and ALU-side signals of the decode stage.
interface rv32i_decode_stage_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [16:0]     full_op;
    logic [XLEN-1:0] op_value1;
    logic [XLEN-1:0] op_value2;
    logic [XLEN-1:0] cmp_a;
    logic [XLEN-1:0] cmp_b;
    logic [XLEN-1:0] link_value;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      rd_addr;
    logic            rd_we;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
        output in_ready, rs1_addr, rs2_addr, out_valid, full_op, op_value1,
               op_value2, cmp_a, cmp_b, link_value, out_pc, rd_addr, rd_we,
               out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, rs1_addr, rs2_addr, out_valid, full_op, op_value1,
               op_value2, cmp_a, cmp_b, link_value, out_pc, rd_addr, rd_we,
               out_illegal
    );
endinterface

// File: rtl/decode_skid_buf.sv
// Two-entry valid/ready skid buffer; in_ready is registered so it has no
// combinational path from out_ready.
module decode_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e       state_q;
    logic         ready_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         push;
    logic         pop;

    assign push        = in_valid_i && ready_q;
    assign pop         = (state_q != EMPTY) && out_ready_i;
    assign in_ready_o  = ready_q;
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush_i) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            ready_q <= 1'b1;
            case (state_q)
                EMPTY: if (push) begin
                    main_q  <= in_data_i;
                    state_q <= ONE;
                end
                ONE: case ({push, pop})
                    2'b10: begin
                        skid_q  <= in_data_i;
                        state_q <= TWO;
                        ready_q <= 1'b0;
                    end
                    2'b11:   main_q  <= in_data_i;
                    2'b01:   state_q <= EMPTY;
                    default: ;
                endcase
                TWO: if (pop) begin
                    main_q  <= skid_q;
                    state_q <= ONE;
                end else begin
                    ready_q <= 1'b0;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end
endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode/operand-issue stage: combinational decode of the incoming word
// into an ALU bundle, queued through a 2-entry skid buffer.
module rv32i_decode_stage
    import rv32i_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32i_decode_stage_if.slave  bus
);
    logic [XLEN-1:0] instr;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd;
    logic [6:0]      f7o;
    logic [2:0]      f3o;
    logic [XLEN-1:0] v1;
    logic [XLEN-1:0] v2;
    logic            wb;
    logic            legal;
    bundle_t         dec;
    bundle_t         held;
    bundle_t         o;
    logic [$bits(bundle_t)-1:0] held_bits;
    logic            hvalid;

    assign instr        = bus.in_instr;
    assign opc          = instr[6:0];
    assign f3           = instr[14:12];
    assign f7           = instr[31:25];
    assign rd           = instr[11:7];
    assign bus.rs1_addr = instr[19:15];
    assign bus.rs2_addr = instr[24:20];

    always_comb begin
        f7o   = '0;
        f3o   = '0;
        v1    = '0;
        v2    = '0;
        wb    = 1'b0;
        legal = 1'b0;
        case (opc)
            OP_R: begin
                legal = (f7 == 7'b0) || (f7 == FUNCT7_ALT && (f3 == 3'b000 || f3 == 3'b101));
                f7o = f7;
                f3o = f3;
                v1  = bus.rs1_data;
                v2  = bus.rs2_data;
                wb  = 1'b1;
            end
            OP_IMM: begin
                f3o = f3;
                v1  = bus.rs1_data;
                wb  = 1'b1;
                // Shifts carry funct7 and a 5-bit shamt instead of an immediate.
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    legal = (f7 == 7'b0) || (f7 == FUNCT7_ALT && f3 == 3'b101);
                    f7o   = f7;
                    v2    = {27'b0, instr[24:20]};
                end else begin
                    legal = 1'b1;
                    v2    = imm_i(instr);
                end
            end
            OP_JAL: begin
                legal = 1'b1;
                v1    = bus.in_pc;
                v2    = imm_j(instr);
                wb    = 1'b1;
            end
            OP_JALR: begin
                legal = (f3 == 3'b000);
                v1    = bus.rs1_data;
                v2    = imm_i(instr);
                wb    = 1'b1;
            end
            OP_LUI: begin
                legal = 1'b1;
                v2    = imm_u(instr);
                wb    = 1'b1;
            end
            OP_AUIPC: begin
                legal = 1'b1;
                v1    = bus.in_pc;
                v2    = imm_u(instr);
                wb    = 1'b1;
            end
            OP_BRANCH: begin
                legal = (f3 != 3'b010) && (f3 != 3'b011);
                f3o   = f3;
                v1    = bus.in_pc;
                v2    = imm_b(instr);
            end
            default: ;
        endcase

        dec         = '0;
        dec.cmp_a   = bus.rs1_data;
        dec.cmp_b   = bus.rs2_data;
        dec.link    = bus.in_pc + 32'd4;
        dec.pc      = bus.in_pc;
        dec.rd      = rd;
        dec.illegal = !legal;
        if (legal) begin
            dec.full_op[FOP_F7_LSB  +: 7] = f7o;
            dec.full_op[FOP_F3_LSB  +: 3] = f3o;
            dec.full_op[FOP_OPC_LSB +: 7] = opc;
            dec.v1    = v1;
            dec.v2    = v2;
            dec.rd_we = wb && (rd != 5'd0);
        end
    end

    decode_skid_buf #(.W($bits(bundle_t))) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (bus.flush),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .in_data_i   (dec),
        .out_valid_o (hvalid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (held_bits)
    );

    assign held = bundle_t'(held_bits);

    // An empty stage presents the reset bundle so stale data never leaks out.
    always_comb begin
        o    = '0;
        o.pc = RESET_PC_TAG;
        if (hvalid) o = held;
    end

    assign bus.out_valid   = hvalid;
    assign bus.full_op     = o.full_op;
    assign bus.op_value1   = o.v1;
    assign bus.op_value2   = o.v2;
    assign bus.cmp_a       = o.cmp_a;
    assign bus.cmp_b       = o.cmp_b;
    assign bus.link_value  = o.link;
    assign bus.out_pc      = o.pc;
    assign bus.rd_addr     = o.rd;
    assign bus.rd_we       = o.rd_we;
    assign bus.out_illegal = o.illegal;
endmodule
